tree_sum_accumulator: RTL

- Consumer at the root of the adder tree; the other end of the tree's reduction output.
- Tracks the tree's fixed latency with a valid/first/last side pipeline and accumulates successive tree sums (input-channel chunks) into one wide accumulator.
- On the last chunk, scales and saturates the result, then delivers it through a valid/ready output FIFO.
- Back-pressures the tree entry with credits, because the tree itself cannot stall.

---
 rtl/tree_sum_accumulator_pkg.sv | 47 ++++
 rtl/result_fifo.sv | 60 ++++++
 rtl/tree_sum_accumulator.sv | 112 +++++++++++
 3 files changed

// File: rtl/tree_sum_accumulator_pkg.sv
// Shared types, default widths and the scale/saturate helper for the
// tree-root accumulator.
package tree_acc_pkg;

   localparam int DEF_IN_WIDTH  = 38;
   localparam int DEF_ACC_WIDTH = 48;
   localparam int DEF_OUT_WIDTH = 32;

   // Side-pipeline tag that travels alongside a chunk through the adder tree.
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tree_tag_t;

   // Scaled/saturated result; value is held at 64 bits so one helper serves
   // any OUT_WIDTH up to 64.
   typedef struct packed {
      logic               sat;
      logic signed [63:0] value;
   } sat_res_t;

   // Arithmetic right shift by scale (rounds toward -inf), then clip to a
   // signed out_w-bit range. sat reports whether clipping happened.
   function automatic sat_res_t sat_shift(input logic signed [63:0] acc,
                                          input int                 scale,
                                          input int                 out_w);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           res;
      r         = acc >>> scale;
      hi        = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo        = -hi - 64'sd1;
      res.sat   = 1'b0;
      res.value = r;
      if (r > hi) begin
         res.sat   = 1'b1;
         res.value = hi;
      end else if (r < lo) begin
         res.sat   = 1'b1;
         res.value = lo;
      end
      return res;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with a register-array head. The head entry is read
// straight out of the storage array, so it holds while not popped.
module result_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_valid,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_full;

   assign w_pop   = i_pop & (r_count != '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign o_data  = r_mem[r_rd];
   assign o_valid = (r_count != '0);
   assign o_count = r_count;

   // Storage, pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
         end
         if (w_pop) begin
            r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The producer's credit scheme guarantees a free slot for every push.
   a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
      !(i_push && w_full && !w_pop));

endmodule

// File: rtl/tree_sum_accumulator.sv
// Root consumer of a fixed-latency adder tree. A {valid,first,last} side
// pipeline tracks chunks through the tree, the root sums are accumulated per
// result, and finished results are scaled, saturated and queued.
//
// Handshakes: the tree entry transfers a chunk on a cycle where
// in_valid & in_ready; the output transfers the FIFO head on a cycle where
// out_valid & out_ready. in_ready depends on registers only, and
// out_data/out_sat stay stable while out_valid & ~out_ready.
module tree_sum_accumulator
   import tree_acc_pkg::*;
#(
   parameter int IN_WIDTH     = DEF_IN_WIDTH,
   parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
   parameter int OUT_SCALE    = 0,
   parameter int TREE_LATENCY = 6,
   parameter int OUT_DEPTH    = 8
) (
   input  logic                        clk,
   input  logic                        arst_n_in,
   input  logic                        in_valid,
   input  logic                        in_first,
   input  logic                        in_last,
   output logic                        in_ready,
   input  logic signed [IN_WIDTH-1:0]  sum_in,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        out_sat,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam int PW = $clog2(TREE_LATENCY + 1);

   tree_tag_t                   r_tag [TREE_LATENCY];
   logic signed [ACC_WIDTH-1:0] r_acc;

   tree_tag_t                   w_d;
   logic                        w_accept;
   logic signed [ACC_WIDTH-1:0] w_sum_ext;
   logic signed [ACC_WIDTH-1:0] w_acc_base;
   logic signed [ACC_WIDTH-1:0] w_acc_next;
   logic signed [63:0]          w_acc64;
   sat_res_t                    w_res;
   logic                        w_push;
   logic                        w_pop;
   logic [OUT_WIDTH:0]          w_fifo_din;
   logic [OUT_WIDTH:0]          w_fifo_dout;
   logic [CW-1:0]               w_fifo_count;
   logic [PW-1:0]               w_pend;

   assign w_accept   = in_valid & in_ready;
   assign w_d        = r_tag[TREE_LATENCY-1];
   assign w_sum_ext  = ACC_WIDTH'(sum_in);
   assign w_acc_base = w_d.first ? '0 : r_acc;
   assign w_acc_next = w_acc_base + w_sum_ext;
   assign w_acc64    = 64'(w_acc_next);
   assign w_res      = sat_shift(w_acc64, OUT_SCALE, OUT_WIDTH);
   assign w_push     = w_d.valid & w_d.last;
   assign w_fifo_din = {w_res.sat, w_res.value[OUT_WIDTH-1:0]};
   assign w_pop      = out_valid & out_ready;
   assign out_data   = w_fifo_dout[OUT_WIDTH-1:0];
   assign out_sat    = w_fifo_dout[OUT_WIDTH];

   // Side pipeline: always shifts; a refused in_valid enters as an empty slot.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         for (int i = 0; i < TREE_LATENCY; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= tree_tag_t'{w_accept, in_first & w_accept, in_last & w_accept};
         for (int i = 1; i < TREE_LATENCY; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   // Accumulator: restart on a first beat, otherwise add onto the running sum.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_acc <= '0;
      end else if (w_d.valid) begin
         r_acc <= w_acc_next;
      end
   end

   // Results still inside the tree already own a FIFO slot.
   always_comb begin
      w_pend = '0;
      for (int i = 0; i < TREE_LATENCY; i++) begin
         if (r_tag[i].valid && r_tag[i].last) w_pend = w_pend + PW'(1);
      end
   end

   assign in_ready = (32'(w_fifo_count) + 32'(w_pend)) < 32'(OUT_DEPTH - 1);

   result_fifo #(
      .WIDTH (OUT_WIDTH + 1),
      .DEPTH (OUT_DEPTH)
   ) u_result_fifo (
      .clk     (clk),
      .arst_n  (arst_n_in),
      .i_push  (w_push),
      .i_data  (w_fifo_din),
      .i_pop   (w_pop),
      .o_data  (w_fifo_dout),
      .o_valid (out_valid),
      .o_count (w_fifo_count)
   );

   // The saturated value must be representable in OUT_WIDTH bits.
   a_res_fits: assert property (@(posedge clk) disable iff (!arst_n_in)
      w_push |-> (w_res.value == 64'(signed'(w_res.value[OUT_WIDTH-1:0]))));

endmodule
